mesh_sram_arbiter: RTL

- Shares the tile's single-port 256x8 SRAM macro (active-low CEN/GWEN) between two requesters: the local core and a network port B, through which the router delivers remote loads and stores.
- The core port is a fixed-latency SRAM interface that cannot stall, so it always has absolute priority.
- Network requests are buffered in a small FIFO and issued only in cycles when the core is idle.
- Read responses are steered back to whichever requester issued the read.

---
 rtl/mesh_tile_pkg.sv | 19 +
 rtl/mesh_cmd_fifo.sv | 56 +++++
 rtl/mesh_sram_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mesh_tile_pkg.sv
// Shared tile types: SRAM geometry, read-owner tag and the network command word.
package mesh_tile_pkg;

    localparam int SRAM_AW = 8;
    localparam int SRAM_DW = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_NET  = 2'd2
    } owner_t;

    typedef struct packed {
        logic               we;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] wdata;
    } b_cmd_t;

endpackage

// File: rtl/mesh_cmd_fifo.sv
// Synchronous FIFO, push visible at head next cycle; push ignored when full, pop ignored when empty.
// Storage carries no reset so it can map onto flops without reset muxes.
module mesh_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mesh_sram_arbiter.sv
// Shares one single-port SRAM between a never-stalling core port (absolute priority) and a
// buffered network port; network commands issue only in core-idle cycles, read data returns next cycle.
module mesh_sram_arbiter
    import mesh_tile_pkg::*;
#(
    parameter int B_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_wen,
    input  logic [SRAM_AW-1:0] a_waddr,
    input  logic [SRAM_DW-1:0] a_wdata,
    input  logic               a_ren,
    input  logic [SRAM_AW-1:0] a_raddr,
    output logic [SRAM_DW-1:0] a_rdata,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic               b_we,
    input  logic [SRAM_AW-1:0] b_addr,
    input  logic [SRAM_DW-1:0] b_wdata,
    output logic               b_rvalid,
    output logic [SRAM_DW-1:0] b_rdata,
    output logic               b_starve,
    output logic               a_conflict,
    output logic               sram_cen,
    output logic               sram_gwen,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [SRAM_DW-1:0] sram_d,
    input  logic [SRAM_DW-1:0] sram_q
);

    localparam int CW = $clog2(B_FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    b_cmd_t          push_cmd;
    b_cmd_t          head_cmd;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_unused;
    logic            push;
    logic            core_wr;
    logic            core_rd;
    logic            net_issue;
    owner_t          owner;
    owner_t          owner_nxt;
    logic [SW-1:0]   starve_cnt;
    logic [SW-1:0]   starve_nxt;

    assign push_cmd    = '{we: b_we, addr: b_addr, wdata: b_wdata};
    assign b_ready     = rst & (fifo_count < CW'(B_FIFO_DEPTH));
    assign push        = b_valid & b_ready;
    assign fifo_unused = fifo_full;

    mesh_cmd_fifo #(
        .DEPTH (B_FIFO_DEPTH),
        .WIDTH ($bits(b_cmd_t))
    ) u_cmd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_cmd),
        .pop      (net_issue),
        .head     (head_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Write wins over a same-cycle core read; the read is simply not issued.
    assign core_wr   = rst & a_wen;
    assign core_rd   = rst & a_ren & ~a_wen;
    assign net_issue = rst & ~a_wen & ~a_ren & ~fifo_empty;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_a    = '0;
        sram_d    = '0;
        owner_nxt = OWN_NONE;
        if (core_wr) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_a    = a_waddr;
            sram_d    = a_wdata;
        end else if (core_rd) begin
            sram_cen  = 1'b0;
            sram_a    = a_raddr;
            owner_nxt = OWN_CORE;
        end else if (net_issue) begin
            sram_cen  = 1'b0;
            sram_gwen = ~head_cmd.we;
            sram_a    = head_cmd.addr;
            sram_d    = head_cmd.wdata;
            if (!head_cmd.we) begin
                owner_nxt = OWN_NET;
            end
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (fifo_empty || net_issue) begin
            starve_nxt = '0;
        end else if ((a_wen || a_ren) && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            b_starve   <= 1'b0;
            a_conflict <= 1'b0;
        end else begin
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
            b_starve   <= (starve_nxt == SW'(STARVE_LIMIT));
            if (a_wen && a_ren) begin
                a_conflict <= 1'b1;
            end
        end
    end

    assign a_rdata  = sram_q;
    assign b_rvalid = rst & (owner == OWN_NET);
    assign b_rdata  = rst ? sram_q : '0;

endmodule
